xor_stream_decimator: RTL and testbench
=======================================

# xor_stream_decimator

Downstream consumer of the block-matching XOR pixel stream. It takes the 1-bit-per-beat XOR bit stream with its per-pixel confidence and disparity and groups every decimate_factor × decimate_factor bits into one output pixel. Each output pixel carries the popcount of its bits plus confidence and disparity. Results are buffered in an internal FIFO with valid/ready output. The block drives the almost-full backpressure that throttles the upstream XOR-to-stream reader.

## Interface
- decimate_factor, 2: bits per column group and columns per output pixel; power of two.
- frame_w, 240: full-resolution frame width in columns; multiple of decimate_factor.
- disparity_bits, 5: significant bits of disp_in / out_disp.
- fifo_depth, 32: output FIFO entries; power of two.
- af_margin, 4: almost-full asserted when occupancy ≥ fifo_depth − af_margin.

- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- pix_stream_data  in  1  XOR bit; qualified by pix_stream_valid.
- pix_stream_valid  in  1  input beat valid.
- conf_in  in  8  confidence aligned with the beat.
- disp_in  in  8  disparity aligned with the beat; only [disparity_bits−1:0] used.
- fifo_almost_full_out  out  1  registered backpressure to the upstream stage.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_count  out  $clog2(decimate_factor²+1)  popcount of the group.
- out_conf  out  8  group confidence.
- out_disp  out  disparity_bits  group disparity.
- out_last  out  1  last output pixel of an output row.

## Operation
- Input order per output row:
  - full-resolution columns 0..frame_w−1 ascending;
  - each column delivers decimate_factor consecutive beats (vertically adjacent bits).
- Counters, advanced only on valid beats:
  - sub_row 0..decimate_factor−1;
  - sub_col 0..decimate_factor−1;
  - out_col 0..frame_w/decimate_factor−1.
  - sub_row wraps → sub_col advances. sub_col wraps → group complete, out_col advances. out_col wraps → 0.
- Accumulator:
  - first beat of a group loads pix_stream_data and captures conf_in and disp_in[disparity_bits−1:0];
  - subsequent beats add pix_stream_data.
  - The accumulator is wide enough for decimate_factor², so no saturation.
- On the final beat of a group, push {count including that beat, captured conf, captured disp, out_col==last} into the FIFO.
- FIFO rules:
  - show-ahead; head appears on out_*;
  - pop when out_valid && out_ready;
  - push accepted if not full, or if a pop occurs in the same cycle;
  - a push while full with no pop drops the entry, and occupancy is unchanged.
- fifo_almost_full_out = registered (occupancy ≥ fifo_depth − af_margin).
  - The margin absorbs the upstream pipeline: up to 2 beats in flight after assertion, which is at most 1 group per margin entry.
- Reset:
  - all counters, accumulator and FIFO pointers cleared;
  - out_valid=0, fifo_almost_full_out=0, out_count/out_conf/out_disp/out_last=0;
  - a partial group in progress is discarded.

## Timing
- A group completes on the beat sampled at edge N; out_valid is high from cycle N+1 if the FIFO was empty.
- The input accepts a beat every cycle. There is no input ready; flow control is fifo_almost_full_out only.
- Pop is visible next cycle: the following entry, or out_valid=0 if the FIFO is empty.
- Simultaneous push and pop:
  - when empty, the pushed entry appears next cycle;
  - when full, occupancy holds at fifo_depth and the entry is stored.
- fifo_almost_full_out lags occupancy by 1 cycle; it deasserts 1 cycle after occupancy drops below threshold.
- Output data must not change while out_valid && !out_ready.

## Configuration
- XOR_DECIM_OVERFLOW_FLAG_EN:
  - defined: adds output port overflow_sticky (1 bit), set the cycle after any dropped push and cleared only by reset;
  - undefined: the port is absent and drops are silent.

## Test plan
- Parameters: decimate_factor=2, frame_w=8, fifo_depth=32, af_margin=4, out_ready=1 unless stated.
- Single group: beats 1,1,0,1 with conf_in=0x40, disp_in=3 → one output out_count=3, out_conf=0x40, out_disp=3, out_last=0, out_valid exactly 1 cycle after the 4th beat.
- Full row, 16 beats all 1, conf changing per beat → 4 outputs each out_count=4, out_conf = first beat of each group, out_last=1 only on the 4th.
- Gapped valid: same 4 beats as the single-group case with pix_stream_valid low between them → identical output; invalid cycles ignored.
- Backpressure, out_ready=0, 28 groups pushed → fifo_almost_full_out rises the cycle after the 28th push. Push 4 more, then a 33rd group → occupancy stays 32, 33rd dropped, overflow_sticky=1 when the macro is defined. Drain with out_ready=1 → 32 entries in order.
- Reset after 2 beats of a group, then beats 0,0,0,1 → single output out_count=1; no stale count; all outputs 0 during reset.

Source files
------------

// File: rtl/xor_stream_decimator.sv
// xor_stream_decimator
//
// Groups the 1-bit-per-beat XOR stream into decimate_factor x decimate_factor
// blocks and emits one output pixel per block: the popcount of its bits plus
// the confidence and disparity captured on the block's first beat. Output
// pixels are queued in a show-ahead FIFO with valid/ready handshake, and a
// registered almost-full flag throttles the upstream reader.
//
// Ports:
//   clk                   single clock
//   reset                 synchronous, active-high
//   pix_stream_data       XOR bit, qualified by pix_stream_valid
//   pix_stream_valid      input beat valid
//   conf_in[7:0]          per-beat confidence
//   disp_in[7:0]          per-beat disparity, low disparity_bits used
//   fifo_almost_full_out  registered backpressure to upstream
//   out_valid             FIFO head valid
//   out_ready             consumer accepts the head
//   out_count             popcount of the block
//   out_conf              confidence of the block
//   out_disp              disparity of the block
//   out_last              last output pixel of an output row
//   overflow_sticky       (XOR_DECIM_OVERFLOW_FLAG_EN only) set after any
//                         dropped push, cleared by reset
//
// Build option: define XOR_DECIM_OVERFLOW_FLAG_EN to add overflow_sticky.

module xor_stream_decimator #(
    parameter int decimate_factor = 2,
    parameter int frame_w         = 240,
    parameter int disparity_bits  = 5,
    parameter int fifo_depth      = 32,
    parameter int af_margin       = 4,
    localparam int count_w        = $clog2(decimate_factor * decimate_factor + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_stream_data,
    input  logic                      pix_stream_valid,
    input  logic [7:0]                conf_in,
    input  logic [7:0]                disp_in,
    output logic                      fifo_almost_full_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [count_w-1:0]        out_count,
    output logic [7:0]                out_conf,
    output logic [disparity_bits-1:0] out_disp,
`ifdef XOR_DECIM_OVERFLOW_FLAG_EN
    output logic                      overflow_sticky,
`endif
    output logic                      out_last
);

    localparam int out_cols = frame_w / decimate_factor;
    localparam int sub_w    = (decimate_factor > 1) ? $clog2(decimate_factor) : 1;
    localparam int col_w    = (out_cols > 1) ? $clog2(out_cols) : 1;
    // Pointers wrap naturally because fifo_depth is a power of two.
    localparam int addr_w   = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int entry_w  = count_w + 8 + disparity_bits + 1;

    localparam logic [sub_w-1:0]  sub_max    = sub_w'(decimate_factor - 1);
    localparam logic [col_w-1:0]  col_max    = col_w'(out_cols - 1);
    localparam logic [addr_w:0]   occ_full   = (addr_w + 1)'(fifo_depth);
    localparam logic [addr_w:0]   af_thresh  = (addr_w + 1)'(fifo_depth - af_margin);

    logic [sub_w-1:0]          sub_row;
    logic [sub_w-1:0]          sub_col;
    logic [col_w-1:0]          out_col;
    logic [count_w-1:0]        acc;
    logic [count_w-1:0]        count_next;
    logic [7:0]                conf_q;
    logic [7:0]                conf_sel;
    logic [disparity_bits-1:0] disp_q;
    logic [disparity_bits-1:0] disp_sel;
    logic                      first_beat;
    logic                      group_done;

    logic [entry_w-1:0]        mem [fifo_depth];
    logic [entry_w-1:0]        push_entry;
    logic [entry_w-1:0]        head;
    logic [addr_w-1:0]         wr_ptr;
    logic [addr_w-1:0]         rd_ptr;
    logic [addr_w:0]           occ;
    logic                      full;
    logic                      push;
    logic                      pop;
    logic                      push_ok;

    generate
        if (disparity_bits < 8) begin : g_disp_unused
            logic unused_disp_hi;
            assign unused_disp_hi = ^disp_in[7:disparity_bits];
        end
    endgenerate

    // ---------------- group accumulation ----------------
    assign first_beat = (sub_row == '0) && (sub_col == '0);
    assign group_done = pix_stream_valid && (sub_row == sub_max) && (sub_col == sub_max);
    assign count_next = first_beat ? count_w'(pix_stream_data)
                                   : acc + count_w'(pix_stream_data);
    // A one-beat group (decimate_factor == 1) must push the live side data.
    assign conf_sel   = first_beat ? conf_in : conf_q;
    assign disp_sel   = first_beat ? disp_in[disparity_bits-1:0] : disp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_row <= '0;
            sub_col <= '0;
            out_col <= '0;
            acc     <= '0;
            conf_q  <= '0;
            disp_q  <= '0;
        end else if (pix_stream_valid) begin
            acc <= count_next;
            if (first_beat) begin
                conf_q <= conf_in;
                disp_q <= disp_in[disparity_bits-1:0];
            end
            if (sub_row == sub_max) begin
                sub_row <= '0;
                if (sub_col == sub_max) begin
                    sub_col <= '0;
                    out_col <= (out_col == col_max) ? '0 : out_col + 1'b1;
                end else begin
                    sub_col <= sub_col + 1'b1;
                end
            end else begin
                sub_row <= sub_row + 1'b1;
            end
        end
    end

    // ---------------- output FIFO ----------------
    assign push_entry = {count_next, conf_sel, disp_sel, (out_col == col_max)};
    assign full       = (occ == occ_full);
    assign push       = group_done;
    assign pop        = out_valid && out_ready;
    // When full, a simultaneous pop frees the slot being written (wr_ptr == rd_ptr).
    assign push_ok    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            occ                  <= '0;
            fifo_almost_full_out <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            fifo_almost_full_out <= (occ >= af_thresh);
        end
    end

`ifdef XOR_DECIM_OVERFLOW_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_sticky <= 1'b0;
        end else if (push && full && !pop) begin
            overflow_sticky <= 1'b1;
        end
    end
`endif

    // Outputs are forced to zero whenever the FIFO is empty so stale memory never shows.
    assign out_valid = (occ != '0);
    assign head      = mem[rd_ptr];
    assign {out_count, out_conf, out_disp, out_last} = out_valid ? head : '0;

endmodule

// File: tb/tb_xor_stream_decimator.sv
module tb_xor_stream_decimator;

    localparam int DF    = 2;
    localparam int FW    = 8;
    localparam int DB    = 5;
    localparam int DEPTH = 32;
    localparam int AFM   = 4;
    localparam int CW    = 3;
    localparam int COLS  = FW / DF;
    localparam int GBEATS = DF * DF;

    logic          clk;
    logic          reset;
    logic          pix_stream_data;
    logic          pix_stream_valid;
    logic [7:0]    conf_in;
    logic [7:0]    disp_in;
    logic          fifo_almost_full_out;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic [7:0]    out_conf;
    logic [DB-1:0] out_disp;
    logic          out_last;
`ifdef XOR_DECIM_OVERFLOW_FLAG_EN
    logic          overflow_sticky;
`endif

    xor_stream_decimator #(
        .decimate_factor(DF),
        .frame_w        (FW),
        .disparity_bits (DB),
        .fifo_depth     (DEPTH),
        .af_margin      (AFM)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .pix_stream_data     (pix_stream_data),
        .pix_stream_valid    (pix_stream_valid),
        .conf_in             (conf_in),
        .disp_in             (disp_in),
        .fifo_almost_full_out(fifo_almost_full_out),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_count           (out_count),
        .out_conf            (out_conf),
        .out_disp            (out_disp),
`ifdef XOR_DECIM_OVERFLOW_FLAG_EN
        .overflow_sticky     (overflow_sticky),
`endif
        .out_last            (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] count;
        logic [7:0]    conf;
        logic [DB-1:0] disp;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    // reference model state: beat index within group, output column
    int          m_beat = 0;
    int          m_col  = 0;
    int          m_sum  = 0;
    int          m_drops = 0;
    logic [7:0]  m_conf;
    logic [DB-1:0] m_disp;

    task automatic model_reset();
        m_beat = 0;
        m_col  = 0;
        m_sum  = 0;
        exp_q.delete();
    endtask

    // Drives one valid beat (sampled at the next rising edge) and updates the model.
    task automatic drive_beat(input logic d, input logic [7:0] c, input logic [7:0] dp);
        exp_t e;
        pix_stream_data  = d;
        conf_in          = c;
        disp_in          = dp;
        pix_stream_valid = 1'b1;
        if (m_beat == 0) begin
            m_sum  = 0;
            m_conf = c;
            m_disp = dp[DB-1:0];
        end
        m_sum = m_sum + int'(d);
        if (m_beat == GBEATS - 1) begin
            e.count = CW'(m_sum);
            e.conf  = m_conf;
            e.disp  = m_disp;
            e.last  = (m_col == COLS - 1);
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            else m_drops++;
            m_beat = 0;
            m_col  = (m_col + 1) % COLS;
        end else begin
            m_beat++;
        end
        @(posedge clk);
        #1;
        pix_stream_valid = 1'b0;
    endtask

    // Scoreboard: every accepted head is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL scoreboard_unexpected: got count=%0d conf=%h disp=%0d last=%0b, none expected",
                         out_count, out_conf, out_disp, out_last);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_count, out_conf, out_disp, out_last} !== mon_e) begin
                    n_mismatched++;
                    $display("FAIL scoreboard_entry: got count=%0d conf=%h disp=%0d last=%0b, want count=%0d conf=%h disp=%0d last=%0b",
                             out_count, out_conf, out_disp, out_last,
                             mon_e.count, mon_e.conf, mon_e.disp, mon_e.last);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic test_reset();
        reset            = 1'b1;
        pix_stream_data  = 1'b0;
        pix_stream_valid = 1'b0;
        conf_in          = 8'h00;
        disp_in          = 8'h00;
        out_ready        = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if ({out_valid, fifo_almost_full_out, out_count, out_conf, out_disp, out_last} !== '0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got valid=%0b af=%0b count=%0d conf=%h disp=%0d last=%0b, want all 0",
                     out_valid, fifo_almost_full_out, out_count, out_conf, out_disp, out_last);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_full_row();
        for (int i = 0; i < COLS * GBEATS; i++)
            drive_beat(1'b1, 8'h10 + 8'(i), 8'(i));
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL full_row_drain: got %0d entries outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_single_group();
        drive_beat(1'b1, 8'h40, 8'd3);
        drive_beat(1'b1, 8'h40, 8'd3);
        drive_beat(1'b0, 8'h40, 8'd3);
        @(negedge clk);
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL single_early_valid: got out_valid=%0b, want 0", out_valid);
        end
        drive_beat(1'b1, 8'h40, 8'd3);
        @(negedge clk);
        n_compared++;
        if ({out_valid, out_count, out_conf, out_disp, out_last} !== {1'b1, 3'd3, 8'h40, 5'd3, 1'b0}) begin
            n_mismatched++;
            $display("FAIL single_latency: got valid=%0b count=%0d conf=%h disp=%0d last=%0b, want 1 3 40 3 0",
                     out_valid, out_count, out_conf, out_disp, out_last);
        end
        @(negedge clk);
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL single_pop_empty: got out_valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_gapped();
        logic [3:0] bits;
        bits = 4'b1011;
        for (int i = 0; i < GBEATS; i++) begin
            drive_beat(bits[i], 8'h40, 8'd3);
            if (i < GBEATS - 1) begin
                repeat (2) @(negedge clk);
                n_compared++;
                if (out_valid !== 1'b0) begin
                    n_mismatched++;
                    $display("FAIL gapped_idle_valid: got out_valid=%0b after beat %0d, want 0", out_valid, i);
                end
            end
        end
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL gapped_drain: got %0d entries outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic drive_group(input int g);
        for (int k = 0; k < GBEATS; k++)
            drive_beat(1'(((g * 7 + 3) >> k) & 1), 8'(g + 8'h80), 8'(g));
    endtask

    task automatic test_backpressure();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int g = 0; g < DEPTH - AFM - 1; g++) drive_group(g);
        repeat (3) @(negedge clk);
        n_compared++;
        if (fifo_almost_full_out !== 1'b0) begin
            n_mismatched++;
            $display("FAIL bp_af_early: got af=%0b with %0d queued, want 0", fifo_almost_full_out, exp_q.size());
        end
        drive_group(DEPTH - AFM - 1);
        repeat (2) @(negedge clk);
        n_compared++;
        if (fifo_almost_full_out !== 1'b1) begin
            n_mismatched++;
            $display("FAIL bp_af_rise: got af=%0b with %0d queued, want 1", fifo_almost_full_out, exp_q.size());
        end
        n_compared++;
        if ({out_valid, out_count, out_conf, out_disp, out_last} !== {1'b1, exp_q[0]}) begin
            n_mismatched++;
            $display("FAIL bp_head_hold: got count=%0d conf=%h disp=%0d, want count=%0d conf=%h disp=%0d",
                     out_count, out_conf, out_disp, exp_q[0].count, exp_q[0].conf, exp_q[0].disp);
        end
        for (int g = DEPTH - AFM; g < DEPTH; g++) drive_group(g);
`ifdef XOR_DECIM_OVERFLOW_FLAG_EN
        @(negedge clk);
        n_compared++;
        if (overflow_sticky !== 1'b0) begin
            n_mismatched++;
            $display("FAIL bp_sticky_early: got overflow_sticky=%0b, want 0", overflow_sticky);
        end
`endif
        drive_group(DEPTH);
        @(negedge clk);
        n_compared++;
        if (m_drops != 1 || exp_q.size() != DEPTH || out_valid !== 1'b1 || fifo_almost_full_out !== 1'b1) begin
            n_mismatched++;
            $display("FAIL bp_full_state: got valid=%0b af=%0b, want 1 1 (model drops=%0d queued=%0d)",
                     out_valid, fifo_almost_full_out, m_drops, exp_q.size());
        end
`ifdef XOR_DECIM_OVERFLOW_FLAG_EN
        n_compared++;
        if (overflow_sticky !== 1'b1) begin
            n_mismatched++;
            $display("FAIL bp_sticky_set: got overflow_sticky=%0b, want 1", overflow_sticky);
        end
`endif
        n_compared++;
        if ({out_count, out_conf, out_disp, out_last} !== exp_q[0]) begin
            n_mismatched++;
            $display("FAIL bp_head_after_drop: got count=%0d conf=%h, want count=%0d conf=%h",
                     out_count, out_conf, exp_q[0].count, exp_q[0].conf);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL bp_drain: got %0d entries outstanding, want 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        n_compared++;
        if ({out_valid, fifo_almost_full_out} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL bp_after_drain: got valid=%0b af=%0b, want 0 0", out_valid, fifo_almost_full_out);
        end
    endtask

    task automatic test_reset_mid_group();
        // Park one whole group in the FIFO, start another, then reset.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive_beat(1'b1, 8'h77, 8'd9);
        drive_beat(1'b0, 8'h77, 8'd9);
        drive_beat(1'b1, 8'h77, 8'd9);
        drive_beat(1'b0, 8'h77, 8'd9);
        drive_beat(1'b1, 8'h66, 8'd2);
        drive_beat(1'b1, 8'h66, 8'd2);
        @(negedge clk);
        n_compared++;
        if (out_valid !== 1'b1) begin
            n_mismatched++;
            $display("FAIL rst_pending_valid: got out_valid=%0b, want 1", out_valid);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_compared++;
        if ({out_valid, fifo_almost_full_out, out_count, out_conf, out_disp, out_last} !== '0) begin
            n_mismatched++;
            $display("FAIL rst_mid_outputs: got valid=%0b af=%0b count=%0d conf=%h disp=%0d last=%0b, want all 0",
                     out_valid, fifo_almost_full_out, out_count, out_conf, out_disp, out_last);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        drive_beat(1'b0, 8'h55, 8'd7);
        drive_beat(1'b0, 8'h55, 8'd7);
        drive_beat(1'b0, 8'h55, 8'd7);
        drive_beat(1'b1, 8'h55, 8'd7);
        @(negedge clk);
        n_compared++;
        if ({out_valid, out_count} !== {1'b1, 3'd1}) begin
            n_mismatched++;
            $display("FAIL rst_fresh_group: got valid=%0b count=%0d, want 1 1", out_valid, out_count);
        end
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL rst_drain: got %0d entries outstanding, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_row();
        test_single_group();
        test_gapped();
        test_backpressure();
        test_reset_mid_group();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
